mseq_gen: RTL

MSEQ_GEN -- requirements
Module: mseq_gen

---
 rtl/mseq_pkg.sv | 38 +++
 rtl/mseq_lfsr_step.sv | 17 +
 rtl/mseq_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mseq_pkg.sv
// mseq_pkg -- shared definitions for the m-sequence generator.
//   state_t       : controller states (IDLE/RUN)
//   default_taps  : maximal-length tap mask for a given LFSR degree (3..16),
//                   in the bit order used by mseq_lfsr_step (bit WIDTH-1 = oldest).
package mseq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 16;

    // Tap (n,k,...) of the classic Fibonacci tables maps to mask bit n-1, k-1, ...
    function automatic logic [15:0] default_taps(input int width);
        logic [15:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0E08;
            13:      taps = 16'h1C80;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h000C;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/mseq_lfsr_step.sv
// mseq_lfsr_step -- one combinational Fibonacci LFSR step.
//   state : current register contents
//   poly  : tap mask (bit i set = state[i] feeds the XOR)
//   step  : state shifted left by one with the feedback bit in the LSB
module mseq_lfsr_step
    import mseq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] step
);

    assign step = {state[WIDTH-2:0], ^(state & poly)};

endmodule

// File: rtl/mseq_gen.sv
// mseq_gen -- programmable m-sequence (LFSR) bit generator.
//   CLK_50MHZ, RST (async, active high)
//   start/stop          : enter / leave RUN (stop wins)
//   cfg_load + cfg_*    : capture tap mask, seed and bit-rate divider (IDLE only)
//   busy                : high in RUN
//   seq_bit, phase      : current sequence bit (MSB of LFSR) and LFSR state
//   bit_stb, period_stb : new bit / first bit of a period
//   data, data_stb      : deserialised byte, only when MSEQ_DESER_EN is defined
// Optional feature macro: MSEQ_DESER_EN (byte deserialiser).
module mseq_gen
    import mseq_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] POLY_DEF = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(4'b0101),
    parameter int               DIV_W    = 8
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_poly,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             busy,
    output logic             seq_bit,
    output logic             bit_stb,
    output logic             period_stb,
    output logic [WIDTH-1:0] phase,
    output logic [7:0]       data,
    output logic             data_stb
);

    // Last bit index of a period: 2^WIDTH-2.
    localparam logic [WIDTH-1:0] LAST_BIT = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t           state;
    logic [WIDTH-1:0] poly;
    logic [WIDTH-1:0] seed;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic             launch;

    mseq_lfsr_step #(.WIDTH(WIDTH)) u_step (
        .state (lfsr),
        .poly  (poly),
        .step  (lfsr_next)
    );

    assign launch  = (state == IDLE) && start && !stop;
    assign busy    = (state == RUN);
    assign seq_bit = lfsr[WIDTH-1];
    assign phase   = lfsr;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            poly       <= POLY_DEF;
            seed       <= SEED_DEF;
            div        <= '0;
            div_cnt    <= '0;
            per_cnt    <= '0;
            lfsr       <= SEED_DEF;
            bit_stb    <= 1'b0;
            period_stb <= 1'b0;
        end else begin
            bit_stb    <= 1'b0;
            period_stb <= 1'b0;
            case (state)
                IDLE: begin
                    // Bit 0 is announced in the first RUN cycle, so the
                    // strobes are raised on the start edge itself. A start
                    // that is accepted takes precedence over cfg_load.
                    if (launch) begin
                        state      <= RUN;
                        lfsr       <= seed;
                        div_cnt    <= '0;
                        per_cnt    <= '0;
                        bit_stb    <= 1'b1;
                        period_stb <= 1'b1;
                    end else if (cfg_load) begin
                        poly <= cfg_poly;
                        seed <= (cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
                        div  <= cfg_div;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (div_cnt == div) begin
                        div_cnt <= '0;
                        bit_stb <= 1'b1;
                        // Forced reload keeps the period at 2^WIDTH-1 bits
                        // even for a non-maximal tap mask.
                        if (per_cnt == LAST_BIT) begin
                            lfsr       <= seed;
                            per_cnt    <= '0;
                            period_stb <= 1'b1;
                        end else begin
                            lfsr    <= lfsr_next;
                            per_cnt <= per_cnt + WIDTH'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MSEQ_DESER_EN
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            data_stb <= 1'b0;
        end else begin
            data_stb <= 1'b0;
            if (launch) begin
                bit_cnt <= '0;
            end else if (bit_stb) begin
                shreg   <= {shreg[6:0], seq_bit};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    data     <= {shreg[6:0], seq_bit};
                    data_stb <= 1'b1;
                end
            end
        end
    end
`else
    assign data     = '0;
    assign data_stb = 1'b0;
`endif

endmodule
